// File: rtl/data_mem_responder.sv
// Single-port word memory target with a valid/ready request and response channel,
// programmable wait states and byte-masked stores. Define MEM_ERR_CHECK_EN for address error checking.

module dmr_byte_lane #(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [7:0]       wdata_i,
  output logic [7:0]       rdata_o
);
  // Storage is intentionally left unreset, like a real SRAM macro.
  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[idx_i] <= wdata_i;
  end

  assign rdata_o = mem_q[idx_i];
endmodule

module data_mem_responder #(
  parameter int ADDR_WDTH = 32,
  parameter int DATA_WDTH = 32,
  parameter int DEPTH     = 256,
  parameter int LATENCY   = 2,
  localparam int BE_WDTH  = DATA_WDTH / 8,
  localparam int IDX_W    = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [ADDR_WDTH-1:0] req_addr_i,
  input  logic [DATA_WDTH-1:0] req_wdata_i,
  input  logic [BE_WDTH-1:0]   req_be_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DATA_WDTH-1:0] rsp_rdata_o,
  output logic                 rsp_err_o
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  typedef struct packed {
    logic                 we;
    logic [ADDR_WDTH-1:0] addr;
    logic [DATA_WDTH-1:0] wdata;
    logic [BE_WDTH-1:0]   be;
  } req_t;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  req_t                 req_q, req_d, req_in, acc;
  logic [DATA_WDTH-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic                 enter_resp;
  logic                 acc_err;
  logic [IDX_W-1:0]     acc_idx;

  logic [BE_WDTH-1:0]        lane_we;
  logic [BE_WDTH-1:0][7:0]   lane_rd;

  assign req_in = '{we: req_we_i, addr: req_addr_i, wdata: req_wdata_i, be: req_be_i};

  // With zero wait states the access uses the request still on the bus at the accept edge.
  assign acc     = (state_q == IDLE) ? req_in : req_q;
  assign acc_idx = acc.addr[IDX_W+1:2];

`ifdef MEM_ERR_CHECK_EN
  assign acc_err = (|acc.addr[1:0]) | (|acc.addr[ADDR_WDTH-1:IDX_W+2]);
`else
  logic unused_addr;
  assign unused_addr = ^{acc.addr[ADDR_WDTH-1:IDX_W+2], acc.addr[1:0]};
  assign acc_err     = 1'b0;
`endif

  for (genvar g = 0; g < BE_WDTH; g++) begin : g_lane
    assign lane_we[g] = enter_resp & acc.we & acc.be[g] & ~acc_err;
    dmr_byte_lane #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_lane (
      .clk_i   (clk_i),
      .we_i    (lane_we[g]),
      .idx_i   (acc_idx),
      .wdata_i (acc.wdata[g*8 +: 8]),
      .rdata_o (lane_rd[g])
    );
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          req_d = req_in;
          if (LATENCY == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (enter_resp) begin
      rdata_d = (acc.we | acc_err) ? '0 : lane_rd;
      err_d   = acc_err;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (2 and 0 wait states) checked every cycle
// against a transaction-level memory model, plus directed literal checks.

module tb_data_mem_responder;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.LATENCY(2)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_we_i(req_we[0]),
    .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]), .req_be_i(req_be[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
    .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0])
  );

  data_mem_responder #(.LATENCY(0)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_we_i(req_we[1]),
    .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]), .req_be_i(req_be[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
    .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1])
  );

  function automatic int lat(int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic logic [31:0] init_val(int w);
    return {8'(w), 8'h5A, ~8'(w), 8'hC3};
  endfunction

  function automatic bit addr_err(logic [31:0] a);
`ifdef MEM_ERR_CHECK_EN
    return (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout(string nm, int k);
    n_vec++;
    n_err++;
    $display("FAIL timeout %s inst %0d (cycle %0d)", nm, k, cyc);
  endtask

  // Transaction-level model: a transaction accepted in cycle a answers in cycle a+L+1,
  // the memory effect lands at that point, and the port is busy until the response handshake.
  bit          busy  [2];
  int          acc_c [2];
  logic        m_we  [2];
  logic [31:0] m_ad  [2];
  logic [31:0] m_wd  [2];
  logic [3:0]  m_be  [2];
  logic [31:0] exp_rd  [2];
  logic        exp_err [2];
  logic [31:0] mm [2][DEPTH];

  task automatic step(int k);
    int         L;
    logic [7:0] idx;
    bit         e, er, ev;
    L = lat(k);
    if (!rst_n) begin
      chk("rst_req_ready", 32'(req_ready[k]), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid[k]), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata[k], 32'd0);
      chk("rst_rsp_err",   32'(rsp_err[k]), 32'd0);
      busy[k] = 1'b0; exp_rd[k] = '0; exp_err[k] = 1'b0;
      return;
    end
    if (busy[k] && cyc == acc_c[k] + L + 1) begin
      idx = m_ad[k][9:2];
      e   = addr_err(m_ad[k]);
      exp_err[k] = e;
      if (m_we[k]) begin
        exp_rd[k] = '0;
        if (!e) for (int b = 0; b < 4; b++)
          if (m_be[k][b]) mm[k][idx][8*b +: 8] = m_wd[k][8*b +: 8];
      end else begin
        exp_rd[k] = e ? 32'd0 : mm[k][idx];
      end
    end
    er = !busy[k];
    ev = busy[k] && (cyc >= acc_c[k] + L + 1);
    chk("req_ready", 32'(req_ready[k]), 32'(er));
    chk("rsp_valid", 32'(rsp_valid[k]), 32'(ev));
    if (ev) begin
      chk("rsp_rdata", rsp_rdata[k], exp_rd[k]);
      chk("rsp_err",   32'(rsp_err[k]), 32'(exp_err[k]));
    end
    if (ev && rsp_ready[k]) begin
      busy[k] = 1'b0;
    end else if (er && req_valid[k]) begin
      busy[k] = 1'b1; acc_c[k] = cyc;
      m_we[k] = req_we[k]; m_ad[k] = req_addr[k]; m_wd[k] = req_wdata[k]; m_be[k] = req_be[k];
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) step(k);
    cyc++;
  end

  // Results of the most recent transaction, captured on its first response cycle.
  int          last_lat, last_acc;
  logic [31:0] last_rd;
  logic        last_err;

  task automatic junk(int k);
    req_valid[k] = 1'($urandom);
    req_we[k]    = 1'($urandom);
    req_addr[k]  = $urandom;
    req_wdata[k] = $urandom;
    req_be[k]    = 4'($urandom);
  endtask

  // Called and returns at posedge+1.
  task automatic txn(int k, bit we, logic [31:0] a, logic [31:0] d, logic [3:0] be, int hold);
    int n, t_acc;
    req_valid[k] = 1'b1; req_we[k] = we; req_addr[k] = a; req_wdata[k] = d; req_be[k] = be;
    n = 0;
    while (!req_ready[k] && n < 64) begin @(posedge clk); #1; n++; end
    if (!req_ready[k]) begin timeout("accept", k); req_valid[k] = 1'b0; return; end
    t_acc = cyc;
    @(posedge clk); #1; junk(k);
    n = 0;
    while (!rsp_valid[k] && n < 64) begin @(posedge clk); #1; junk(k); n++; end
    if (!rsp_valid[k]) begin timeout("response", k); req_valid[k] = 1'b0; return; end
    last_lat = cyc - t_acc; last_acc = t_acc;
    last_rd  = rsp_rdata[k]; last_err = rsp_err[k];
    repeat (hold) begin @(posedge clk); #1; junk(k); end
    req_valid[k] = 1'b0; rsp_ready[k] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[k] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 0; req_we[k] = 0; req_addr[k] = 0; req_wdata[k] = 0; req_be[k] = 0;
      rsp_ready[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int k = 0; k < 2; k++)
      for (int w = 0; w < DEPTH; w++) txn(k, 1'b1, 32'(w * 4), init_val(w), 4'hF, 0);

    // Two-wait-state instance: store/load, byte mask, backpressure, empty mask.
    txn(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    chk("store_rdata", last_rd, 32'd0);
    chk("latency_L2", 32'(last_lat), 32'd3);
    txn(0, 0, 32'h10, 32'h0, 4'h0, 0);
    chk("load_after_store", last_rd, 32'hDEADBEEF);
    txn(0, 1, 32'h10, 32'h11223344, 4'b0101, 0);
    txn(0, 0, 32'h10, 32'h0, 4'h0, 0);
    chk("byte_mask", last_rd, 32'hDE22BE44);
    txn(0, 0, 32'h10, 32'h0, 4'h0, 5);
    chk("backpressure_rdata", last_rd, 32'hDE22BE44);
    txn(0, 1, 32'h10, 32'hFFFFFFFF, 4'h0, 0);
    txn(0, 0, 32'h10, 32'h0, 4'h0, 0);
    chk("empty_mask", last_rd, 32'hDE22BE44);

    txn(0, 1, 32'h12, 32'h0BADF00D, 4'hF, 0);
`ifdef MEM_ERR_CHECK_EN
    chk("misaligned_err", 32'(last_err), 32'd1);
    txn(0, 0, 32'h10, 32'h0, 4'h0, 0);
    chk("misaligned_nowrite", last_rd, 32'hDE22BE44);
    txn(0, 0, 32'(DEPTH * 4), 32'h0, 4'h0, 0);
    chk("oor_err", 32'(last_err), 32'd1);
    chk("oor_rdata", last_rd, 32'd0);
`else
    chk("misaligned_err", 32'(last_err), 32'd0);
    txn(0, 0, 32'h10, 32'h0, 4'h0, 0);
    chk("misaligned_write", last_rd, 32'h0BADF00D);
    txn(0, 0, 32'(DEPTH * 4), 32'h0, 4'h0, 0);
    chk("wrap_err", 32'(last_err), 32'd0);
    chk("wrap_rdata", last_rd, init_val(0));
`endif

    // Zero-wait-state instance: back-to-back loads.
    prev = 0;
    for (int i = 1; i <= 4; i++) begin
      txn(1, 0, 32'(i * 4), 32'h0, 4'h0, 0);
      chk("latency_L0", 32'(last_lat), 32'd1);
      chk("l0_rdata", last_rd, init_val(i));
      if (i > 1) chk("l0_spacing", 32'(last_acc - prev), 32'd2);
      prev = last_acc;
    end

    // Reset during wait states: store must be dropped, outputs clear immediately.
    req_valid[0] = 1; req_we[0] = 1; req_addr[0] = 32'h20; req_wdata[0] = 32'h12345678; req_be[0] = 4'hF;
    @(posedge clk); #1 req_valid[0] = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ready", 32'(req_ready[0]), 32'd1);
    chk("async_rst_valid", 32'(rsp_valid[0]), 32'd0);
    chk("async_rst_rdata", rsp_rdata[0], 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    txn(0, 0, 32'h20, 32'h0, 4'h0, 0);
    chk("aborted_store", last_rd, init_val(8));

    // Random traffic on both instances.
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 150; i++) begin
        logic [31:0] a;
        case ($urandom_range(0, 9))
          0:       a = $urandom;
          1:       a = {22'd0, 8'($urandom), 2'($urandom)};
          default: a = {22'd0, 8'($urandom), 2'b00};
        endcase
        txn(k, 1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3));
      end

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
